// File: rtl/hatch_seq.sv
// hatch_seq: egg-hatching sequencer producing the dot-matrix pattern index and status flags.
// Optional macro HATCH_CHICK_ANIM_EN animates the DONE pattern between 9 and 10.
module hatch_seq #(
  parameter int unsigned CLK_HZ    = 1000,
  parameter int unsigned STAGE_SEC = 2,
  parameter int unsigned HATCH_SEC = 3,
  parameter int unsigned ALARM_SEC = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       st,
  input  logic       temp,
  output logic [3:0] num,
  output logic       busy,
  output logic       done,
  output logic       fail
);

  localparam int unsigned StageCyc = STAGE_SEC * CLK_HZ;
  localparam int unsigned AlarmCyc = ALARM_SEC * CLK_HZ;
  localparam int unsigned HatchCyc = HATCH_SEC * CLK_HZ;
  localparam int unsigned HalfCyc  = CLK_HZ / 2;

  // Guard against zero-width counters for degenerate parameter choices.
  localparam int unsigned DwellW = (StageCyc > 1) ? $clog2(StageCyc) : 1;
  localparam int unsigned BadW   = (AlarmCyc > 1) ? $clog2(AlarmCyc) : 1;
  localparam int unsigned HatchW = (HatchCyc > 1) ? $clog2(HatchCyc) : 1;
  localparam int unsigned PhaseW = (HalfCyc > 1) ? $clog2(HalfCyc) : 1;

  localparam logic [DwellW-1:0] DwellLast = DwellW'(StageCyc - 1);
  localparam logic [BadW-1:0]   BadLast   = BadW'(AlarmCyc - 1);
  localparam logic [HatchW-1:0] HatchLast = HatchW'(HatchCyc - 1);
  localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(HalfCyc - 1);

  typedef enum logic [2:0] {
    StIdle,
    StGrow,
    StWarn,
    StHatch,
    StDone,
    StFail
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        stage_q, stage_d;
  logic [DwellW-1:0] dwell_q, dwell_d;
  logic [BadW-1:0]   bad_q, bad_d;
  logic [HatchW-1:0] hatch_q, hatch_d;
  logic [PhaseW-1:0] phase_q, phase_d;
  logic [3:0]        num_q, num_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              fail_q, fail_d;

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    dwell_d = dwell_q;
    bad_d   = bad_q;
    hatch_d = hatch_q;
    phase_d = phase_q;
    num_d   = num_q;

    if (!st) begin
      state_d = StIdle;
      stage_d = '0;
      dwell_d = '0;
      bad_d   = '0;
      hatch_d = '0;
      phase_d = '0;
      num_d   = 4'd0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StGrow;
          stage_d = '0;
          dwell_d = '0;
          num_d   = 4'd0;
        end
        StGrow: begin
          // A temperature fault wins over stage advance; dwell holds this cycle.
          if (!temp) begin
            state_d = StWarn;
            bad_d   = '0;
            num_d   = 4'd8;
          end else if (dwell_q == DwellLast) begin
            dwell_d = '0;
            if (stage_q == 3'd5) begin
              state_d = StHatch;
              stage_d = '0;
              hatch_d = '0;
              phase_d = '0;
              num_d   = 4'd6;
            end else begin
              stage_d = stage_q + 3'd1;
              num_d   = {1'b0, stage_q + 3'd1};
            end
          end else begin
            dwell_d = dwell_q + DwellW'(1);
            num_d   = {1'b0, stage_q};
          end
        end
        StWarn: begin
          if (temp) begin
            state_d = StGrow;
            bad_d   = '0;
            num_d   = {1'b0, stage_q};
          end else if (bad_q == BadLast) begin
            state_d = StFail;
            bad_d   = '0;
            num_d   = 4'd11;
          end else begin
            bad_d = bad_q + BadW'(1);
            num_d = 4'd8;
          end
        end
        StHatch: begin
          if (hatch_q == HatchLast) begin
            state_d = StDone;
            hatch_d = '0;
            phase_d = '0;
            num_d   = 4'd9;
          end else begin
            hatch_d = hatch_q + HatchW'(1);
            if (phase_q == PhaseLast) begin
              phase_d = '0;
              num_d   = (num_q == 4'd6) ? 4'd7 : 4'd6;
            end else begin
              phase_d = phase_q + PhaseW'(1);
            end
          end
        end
        StDone: begin
`ifdef HATCH_CHICK_ANIM_EN
          if (phase_q == PhaseLast) begin
            phase_d = '0;
            num_d   = (num_q == 4'd9) ? 4'd10 : 4'd9;
          end else begin
            phase_d = phase_q + PhaseW'(1);
          end
`else
          num_d = 4'd9;
`endif
        end
        StFail: begin
          num_d = 4'd11;
        end
        default: begin
          state_d = StIdle;
          num_d   = 4'd0;
        end
      endcase
    end

    busy_d = (state_d == StGrow) || (state_d == StWarn) || (state_d == StHatch);
    done_d = (state_d == StDone);
    fail_d = (state_d == StFail);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      stage_q <= '0;
      dwell_q <= '0;
      bad_q   <= '0;
      hatch_q <= '0;
      phase_q <= '0;
      num_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      dwell_q <= dwell_d;
      bad_q   <= bad_d;
      hatch_q <= hatch_d;
      phase_q <= phase_d;
      num_q   <= num_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
    end
  end

  assign num  = num_q;
  assign busy = busy_q;
  assign done = done_q;
  assign fail = fail_q;

endmodule

// File: tb/tb_hatch_seq.sv
// tb_hatch_seq: directed and randomized bench for hatch_seq, checked every cycle against a
// progress-count model (growth cycles, warn run length, hatch/done elapsed time).
module tb_hatch_seq;

  localparam int unsigned ClkHz    = 4;
  localparam int unsigned StageSec = 1;
  localparam int unsigned HatchSec = 2;
  localparam int unsigned AlarmSec = 2;

  localparam int StageCyc = StageSec * ClkHz;
  localparam int GrowCyc  = 6 * StageCyc;
  localparam int HatchCyc = HatchSec * ClkHz;
  localparam int AlarmCyc = AlarmSec * ClkHz;
  localparam int Half     = ClkHz / 2;

`ifdef HATCH_CHICK_ANIM_EN
  localparam int Anim = 1;
`else
  localparam int Anim = 0;
`endif

  localparam int MIdle  = 0;
  localparam int MGrow  = 1;
  localparam int MWarn  = 2;
  localparam int MHatch = 3;
  localparam int MDone  = 4;
  localparam int MFail  = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       st = 1'b0;
  logic       temp = 1'b1;
  logic [3:0] num;
  logic       busy, done, fail;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  int m_mode = MIdle;
  int m_prog = 0;
  int m_warn = 0;
  int m_t    = 0;
  int m_d    = 0;

  hatch_seq #(
    .CLK_HZ   (ClkHz),
    .STAGE_SEC(StageSec),
    .HATCH_SEC(HatchSec),
    .ALARM_SEC(AlarmSec)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .st  (st),
    .temp(temp),
    .num (num),
    .busy(busy),
    .done(done),
    .fail(fail)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_num();
    case (m_mode)
      MGrow:   return m_prog / StageCyc;
      MWarn:   return 8;
      MHatch:  return 6 + (m_t / Half) % 2;
      MDone:   return (Anim != 0) ? 9 + (m_d / Half) % 2 : 9;
      MFail:   return 11;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = MIdle;
    m_prog = 0;
    m_warn = 0;
    m_t    = 0;
    m_d    = 0;
  endtask

  // Model: growth is a count of temp-OK GROW cycles; stage is that count divided by stage length.
  task automatic model_step(input logic s, input logic t);
    if (!s) begin
      model_reset();
    end else begin
      case (m_mode)
        MIdle: begin
          m_mode = MGrow;
          m_prog = 0;
        end
        MGrow: begin
          if (!t) begin
            m_mode = MWarn;
            m_warn = 0;
          end else begin
            m_prog++;
            if (m_prog == GrowCyc) begin
              m_mode = MHatch;
              m_t    = 0;
            end
          end
        end
        MWarn: begin
          if (t) begin
            m_mode = MGrow;
          end else begin
            m_warn++;
            if (m_warn == AlarmCyc) m_mode = MFail;
          end
        end
        MHatch: begin
          m_t++;
          if (m_t == HatchCyc) begin
            m_mode = MDone;
            m_d    = 0;
          end
        end
        MDone:   m_d++;
        default: ;
      endcase
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("num", int'(num), exp_num());
      check("busy", int'(busy), int'(m_mode == MGrow || m_mode == MWarn || m_mode == MHatch));
      check("done", int'(done), int'(m_mode == MDone));
      check("fail", int'(fail), int'(m_mode == MFail));
    end
  end

  task automatic step(input logic s, input logic t);
    st   = s;
    temp = t;
    @(posedge clk);
    model_step(s, t);
    @(negedge clk);
  endtask

  // Called just after a negedge: asynchronous pulse held across one rising edge.
  task automatic pulse_rst();
    #2 rst = 1'b1;
    #1;
    check("rst_async_num", int'(num), 0);
    check("rst_async_busy", int'(busy), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    int bad_pct;
    model_reset();
    #2 rst = 1'b1;
    #1;
    check("por_num", int'(num), 0);
    check("por_done", int'(done), 0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;

    // Full run with temp OK: 0..5 x4, then 6,6,7,7,6,6,7,7, then DONE.
    for (int i = 0; i < 24; i++) begin
      step(1'b1, 1'b1);
      check("seq_grow", int'(num), i / 4);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1);
      check("seq_hatch", int'(num), ((i / 2) % 2 == 1) ? 7 : 6);
      check("seq_hatch_busy", int'(busy), 1);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1);
      check("seq_done", int'(num), (Anim != 0) ? 9 + (i / 2) % 2 : 9);
      check("seq_done_flag", int'(done), 1);
      check("seq_done_busy", int'(busy), 0);
    end

    // Async reset in stage 3, then restart from stage 0.
    step(1'b0, 1'b1);
    for (int i = 0; i < 14; i++) step(1'b1, 1'b1);
    check("t1_stage3", int'(num), 3);
    pulse_rst();
    step(1'b1, 1'b1);
    check("t1_restart_num", int'(num), 0);
    check("t1_restart_busy", int'(busy), 1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
    check("t1_stage1", int'(num), 1);

    // Short temperature excursion in stage 2.
    step(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
    check("t3_stage2", int'(num), 2);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      check("t3_warn", int'(num), 8);
    end
    step(1'b1, 1'b1);
    check("t3_back", int'(num), 2);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    check("t3_still2", int'(num), 2);
    step(1'b1, 1'b1);
    check("t3_stage3", int'(num), 3);
    check("t3_nofail", int'(fail), 0);

    // Sustained fault in stage 1 ends in FAIL.
    step(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
    check("t4_stage1", int'(num), 1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0);
      check("t4_warn", int'(num), 8);
    end
    step(1'b1, 1'b0);
    check("t4_fail_num", int'(num), 11);
    check("t4_fail_flag", int'(fail), 1);
    check("t4_fail_busy", int'(busy), 0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    check("t4_fail_hold", int'(num), 11);
    step(1'b0, 1'b1);
    check("t4_idle", int'(num), 0);

    // st dropped during HATCH.
    for (int i = 0; i < 25; i++) step(1'b1, 1'b1);
    check("t5_hatch", int'(num), 6);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    check("t5_idle_num", int'(num), 0);
    check("t5_idle_busy", int'(busy), 0);
    step(1'b1, 1'b1);
    check("t5_restart", int'(num), 0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
    check("t5_stage1", int'(num), 1);

    // Randomized episodes with varying fault density.
    bad_pct = 0;
    for (int i = 0; i < 4000; i++) begin
      if (i % 60 == 0) begin
        case ($urandom_range(0, 3))
          0:       bad_pct = 0;
          1:       bad_pct = 3;
          2:       bad_pct = 40;
          default: bad_pct = 90;
        endcase
      end
      if ($urandom_range(0, 499) == 0) pulse_rst();
      step(($urandom_range(0, 199) != 0) ? 1'b1 : 1'b0,
           (int'($urandom_range(0, 99)) < bad_pct) ? 1'b0 : 1'b1);
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hatch_seq.md
# hatch_seq

Sequencer for the egg-hatching display path. It decides which dot-matrix pattern index is shown and when, and drives the `num` input of the dot-matrix row-scan driver. It steps the egg through growth stages, pauses and warns on bad temperature, fails the hatch after a sustained temperature fault, and ends in a hatched-chick state. It runs on the same 1 kHz scan clock as the display driver.

## Interface

**Parameters**
- `CLK_HZ`, default 1000: clock frequency; must be even and ≥ 2.
- `STAGE_SEC`, default 2: seconds each growth stage (0..5) is held while temperature is OK.
- `HATCH_SEC`, default 3: seconds of the hatching animation.
- `ALARM_SEC`, default 5: continuous seconds of bad temperature before the hatch fails.

**Ports**
- `clk` in 1: scan clock.
- `rst` in 1: reset. One clock; reset is asynchronous and active-high.
- `st` in 1: run enable, level. 0 forces IDLE.
- `temp` in 1: 1 = temperature OK, 0 = out of range. Synchronous to `clk`.
- `num` out 4: pattern index for the display driver.
- `busy` out 1: high in GROW, WARN or HATCH.
- `done` out 1: high in DONE.
- `fail` out 1: high in FAIL.

## Operation

States: IDLE, GROW, WARN, HATCH, DONE, FAIL. All outputs are registered.

**Reset and `st`**
- Reset values: state=IDLE, `num`=0, `busy`=0, `done`=0, `fail`=0, stage=0, all counters=0.
- `st`=0 in any state: next cycle goes to IDLE and all counters clear. This takes priority over every other transition.

**IDLE**
- `num`=0.
- When `st`=1, go to GROW with stage=0 and dwell=0.

**GROW**
- `num` = stage (0..5).
- dwell increments each cycle.
- When dwell = STAGE_SEC·CLK_HZ−1: dwell clears and stage increments.
- If stage was 5 at that point, go to HATCH instead.
- If `temp`=0 in a GROW cycle, go to WARN; dwell holds its value and does not increment that cycle.

**WARN**
- `num`=8.
- bad counter increments each cycle. dwell and stage are frozen.
- `temp`=1: bad counter clears and state returns to GROW with the same stage. dwell resumes from its held value.
- bad counter = ALARM_SEC·CLK_HZ−1 while `temp`=0: go to FAIL.

**HATCH**
- `num` alternates 6 and 7, starting with 6. It toggles every CLK_HZ/2 cycles (phase counter).
- `temp` is ignored.
- After HATCH_SEC·CLK_HZ cycles, go to DONE.

**DONE**
- `num`=9. See Configuration for the animated variant.
- Stays in DONE until `st`=0.

**FAIL**
- `num`=11.
- Stays in FAIL until `st`=0. Raising `st` again from IDLE restarts at stage 0.

**Counter widths**
- dwell: $clog2(STAGE_SEC·CLK_HZ).
- bad: $clog2(ALARM_SEC·CLK_HZ).
- hatch: $clog2(HATCH_SEC·CLK_HZ).
- phase: $clog2(CLK_HZ/2).
- No counter wraps; each one is cleared on its terminal condition.

**Simultaneous events**
- `temp` falls in the same cycle dwell reaches its terminal value: WARN wins and the stage does not advance.
- `temp` returns on the same cycle the bad counter reaches its terminal value: GROW wins.

## Timing

- State register and outputs update on the same `clk` edge, so `num` reflects the new state one cycle after the deciding input.
- Asynchronous `rst` clears outputs immediately, with no clock needed. After `rst` falls, the first active edge behaves as a normal IDLE cycle.
- `st` is sampled synchronously. Its fall produces `num`=0 and `busy`=0 one cycle later.
- Total growth time with `temp` held at 1 is exactly 6·STAGE_SEC·CLK_HZ cycles from the first GROW cycle to the first HATCH cycle.
- Cycles spent in WARN extend the total growth time one for one.

## Configuration

- `HATCH_CHICK_ANIM_EN` defined: DONE alternates `num` between 9 and 10, starting with 9, toggling every CLK_HZ/2 cycles using the same phase counter.
- `HATCH_CHICK_ANIM_EN` not defined: DONE holds `num`=9 and the phase counter is used only in HATCH.

## Test plan

All cases use CLK_HZ=4, STAGE_SEC=1, HATCH_SEC=2, ALARM_SEC=2.

1. Pulse `rst` mid-clock while in GROW stage 3 → `num`=0, `busy`=0 and state=IDLE immediately. After release with `st`=1, `num` restarts at 0.
2. `st`=1, `temp`=1 held → `num` = 0,1,2,3,4,5, each held 4 cycles. Then 6,7,6,7, each held 2 cycles. Then 9 with `done`=1 and `busy`=0.
3. In stage 2, `temp`=0 for 3 cycles, then 1 → `num`=8 for 3 cycles, then back to 2. Stage 2 total dwell in GROW is still 4 cycles. `fail` stays 0.
4. In stage 1, `temp`=0 held → `num`=8 for 8 cycles, then 11 with `fail`=1 and `busy`=0. `temp`=1 afterwards has no effect. `st`=0 gives `num`=0 the next cycle.
5. `st` dropped for 1 cycle during HATCH → IDLE with `num`=0. `st`=1 again restarts at `num`=0 with full stage timing.
6. Build with `HATCH_CHICK_ANIM_EN` and run to DONE → `num` alternates 9/10 every 2 cycles. Without the macro → `num` stays at 9.
